// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for serial_adder (sub port under SERIAL_ADDER_SUB_EN)
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADDER_SUB_EN
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input in_ready, out_valid, sum, cout, busy);
  modport slave  (input in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, busy);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input in_ready, out_valid, sum, cout, busy);
  modport slave  (input in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, busy);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one bit per clock; SERIAL_ADDER_SUB_EN adds a-b via the sub port
module serial_adder #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic clk,
  input logic rst,
  serial_adder_if.slave io
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   b_ld;
  logic               c_ld, s, maj;
`ifdef SERIAL_ADDER_SUB_EN
  // subtraction is a + ~b + 1
  assign b_ld = io.sub ? ~io.b : io.b;
  assign c_ld = io.sub ? 1'b1 : io.cin;
`else
  assign b_ld = io.b;
  assign c_ld = io.cin;
`endif
  assign s   = a_q[0] ^ b_q[0] ^ carry_q;
  assign maj = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (io.in_valid) begin
        a_d     = io.a;
        b_d     = b_ld;
        carry_d = c_ld;
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        sum_d   = {s, sum_q[WIDTH-1:1]};
        carry_d = maj;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? DONE : BUSY;
      end
      DONE:    state_d = io.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end
  assign io.in_ready  = state_q == IDLE;
  assign io.busy      = state_q == BUSY;
  assign io.out_valid = state_q == DONE;
  assign io.sum       = sum_q;
  assign io.cout      = carry_q;
endmodule
